// File: rtl/cnt26_ld_if.sv
// Control/status bundle for the loadable down-counter.
// The master drives the strobes and load value; the counter drives the registered status.
interface cnt26_ld_if #(parameter int WIDTH = 26);
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             dec;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc;
  logic             busy;

  modport master (output clr, ld, d, dec, input  q, zero, tc, busy);
  modport slave  (input  clr, ld, d, dec, output q, zero, tc, busy);
endinterface

// File: rtl/cnt26_ld.sv
// Loadable down-counter with a registered zero flag, a one-cycle terminal-count pulse
// and optional reload of the last loaded value when the count expires.
//
// state | meaning
// IDLE  | never loaded, or cleared
// RUN   | count > 0, decrements accepted
// DONE  | count reached 0 (load of 0, or countdown finished)
module cnt26_ld #(
  parameter int WIDTH      = 26,
  parameter bit AUTORELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  cnt26_ld_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_r, q_nx;
  logic [WIDTH-1:0] reload_r, reload_nx;
  logic             tc_r, tc_nx;
  logic             zero_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q_r      <= '0;
      reload_r <= '0;
      tc_r     <= 1'b0;
      zero_r   <= 1'b1;
    end else begin
      state    <= state_nx;
      q_r      <= q_nx;
      reload_r <= reload_nx;
      tc_r     <= tc_nx;
      // Derived from the next count so zero never lags q.
      zero_r   <= (q_nx == '0);
    end
  end

  always_comb begin
    state_nx  = state;
    q_nx      = q_r;
    reload_nx = reload_r;
    tc_nx     = 1'b0;
    if (bus.clr) begin
      state_nx = IDLE;
      q_nx     = '0;
    end else if (bus.ld) begin
      q_nx      = bus.d;
      reload_nx = bus.d;
      if (bus.d != '0) begin
        state_nx = RUN;
      end else begin
        state_nx = DONE;
        tc_nx    = 1'b1;
      end
    end else if (bus.dec && state == RUN && q_r != '0) begin
      if (q_r == ONE) begin
        tc_nx = 1'b1;
        if (AUTORELOAD) begin
          q_nx = reload_r;
        end else begin
          q_nx     = '0;
          state_nx = DONE;
        end
      end else begin
        q_nx = q_r - ONE;
      end
    end
  end

  always_comb begin
    bus.q    = q_r;
    bus.zero = zero_r;
    bus.tc   = tc_r;
    bus.busy = (state == RUN);
  end

endmodule
